bch_lookup_arb: RTL and testbench

Round-robin arbiter and sequencer sharing one BCH(63,56) syndrome-to-error-position ROM among N_REQ syndrome producers in the decoder, such as parallel decode lanes or s1/s2 channels.
- Accepts req/syn from each requester, grants one at a time, and drives the shared ROM.
- Returns the error position tagged with the requester id over a valid/ready output.
- Replaces per-channel duplicated tables with one registered table.

---
 rtl/bch_pkg.sv | 24 ++
 rtl/bch_lookup_arb_rom.sv | 19 +
 rtl/bch_lookup_arb.sv | 124 ++++++++++++
 tb/tb_bch_lookup_arb.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared constants and types for the BCH(63,56) lookup arbiter.
// POS_TABLE maps a GF(2^6) syndrome alpha^j to error position j+1.
package bch_pkg;

  localparam int SYN_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    HOLD
  } state_t;

  localparam logic [SYN_W-1:0] POS_TABLE [64] = '{
    6'd0,  6'd1,  6'd2,  6'd7,  6'd3,  6'd13, 6'd8,  6'd27,
    6'd4,  6'd33, 6'd14, 6'd36, 6'd9,  6'd49, 6'd28, 6'd19,
    6'd5,  6'd25, 6'd34, 6'd17, 6'd15, 6'd53, 6'd37, 6'd55,
    6'd10, 6'd46, 6'd50, 6'd39, 6'd29, 6'd42, 6'd20, 6'd57,
    6'd6,  6'd63, 6'd26, 6'd12, 6'd35, 6'd32, 6'd18, 6'd48,
    6'd16, 6'd24, 6'd54, 6'd52, 6'd38, 6'd45, 6'd56, 6'd41,
    6'd11, 6'd62, 6'd47, 6'd31, 6'd51, 6'd23, 6'd40, 6'd44,
    6'd30, 6'd61, 6'd43, 6'd22, 6'd21, 6'd60, 6'd58, 6'd59
  };

endpackage

// File: rtl/bch_lookup_arb_rom.sv
// Registered syndrome-to-position ROM.
// One-cycle read; output holds while en is low.
module gf64_pos_rom
  import bch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SYN_W-1:0] addr,
  output logic [SYN_W-1:0] data
);

  // registered table read, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) data <= '0;
    else if (en) data <= POS_TABLE[addr];
  end

endmodule

// File: rtl/bch_lookup_arb.sv
// Round-robin arbiter sharing one syndrome-to-position ROM.
// Grants one requester per lookup; result held until accepted.
module bch_lookup_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int SYN_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*SYN_W-1:0] syn,
  output logic [N_REQ-1:0]       gnt,
  output logic                   out_valid,
  output logic [SYN_W-1:0]       out_pos,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_noerr,
  input  logic                   out_ready,
  output logic                   busy
);

  import bch_pkg::*;

  state_t           state;
  state_t           state_n;
  logic             arb;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  id_l;
  logic [SYN_W-1:0] syn_l;
  logic [SYN_W-1:0] syn_arr [N_REQ];
  logic [ID_W-1:0]  ptr_n;

  // unpack per-requester syndromes
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      syn_arr[i] = syn[i*SYN_W +: SYN_W];
    end
  end

  // first asserted req scanning upward from ptr, wrapping
  always_comb begin
    int idx;
    sel = '0;
    idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[ID_W'(idx)]) sel = ID_W'(idx);
    end
  end

  assign ptr_n = (id_l == ID_W'(N_REQ - 1)) ? '0 : id_l + ID_W'(1);

  // next state and arbitration strobe
  always_comb begin
    state_n = state;
    arb     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          arb     = 1'b1;
          state_n = LOOKUP;
        end
      end
      LOOKUP: state_n = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (|req) begin
            arb     = 1'b1;
            state_n = LOOKUP;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  // grant, capture, result and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      syn_l     <= '0;
      id_l      <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_noerr <= 1'b0;
    end else begin
      gnt <= '0;
      if (arb) begin
        gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
        syn_l <= syn_arr[sel];
        id_l  <= sel;
      end
      if (state == LOOKUP) begin
        out_valid <= 1'b1;
        out_id    <= id_l;
        out_noerr <= (syn_l == '0);
        ptr       <= ptr_n;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  gf64_pos_rom u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (state == LOOKUP),
    .addr (syn_l),
    .data (out_pos)
  );

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bch_lookup_arb.sv
// Self-checking bench for bch_lookup_arb.
// Reference positions come from a GF(2^6) discrete-log model.
module tb_bch_lookup_arb;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int SW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*SW-1:0] syn;
  logic [N-1:0]    gnt;
  logic            out_valid;
  logic [SW-1:0]   out_pos;
  logic [IW-1:0]   out_id;
  logic            out_noerr;
  logic            out_ready;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  int sv [N];

  always #5 clk = ~clk;

  bch_lookup_arb #(.N_REQ(N), .ID_W(IW), .SYN_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .syn       (syn),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_pos   (out_pos),
    .out_id    (out_id),
    .out_noerr (out_noerr),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // position = 1 + log_alpha(s), alpha root of x^6+x+1
  function automatic int gf_pos(int s);
    int v;
    if (s == 0) return 0;
    v = 1;
    for (int j = 0; j < 63; j++) begin
      if (v == s) return j + 1;
      v = v << 1;
      if (v >= 64) v = v ^ 67;
    end
    return -1;
  endfunction

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic drive_syn();
    for (int i = 0; i < N; i++) syn[i*SW +: SW] = SW'(sv[i]);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) sv[i] = 0;
    drive_syn();
    apply_reset();
    checks++;
    if (gnt !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: gnt=%b valid=%b busy=%b want 0 0 0",
               gnt, out_valid, busy);
    end
    checks++;
    if (out_pos !== '0 || out_id !== '0 || out_noerr !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: pos=%0d id=%0d noerr=%b want 0 0 0",
               out_pos, out_id, out_noerr);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b gnt=%b want 0 0", busy, gnt);
    end
  endtask

  task automatic test_single();
    sv[0] = 5;
    drive_syn();
    req = 4'b0001;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt: gnt=%b busy=%b valid=%b want 0001 1 0",
               gnt, busy, out_valid);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pos !== 6'd13 || out_id !== 2'd0 ||
        out_noerr !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL single_res: v=%b pos=%0d id=%0d ne=%b gnt=%b want 1 13 0 0 0",
               out_valid, out_pos, out_id, out_noerr, gnt);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: v=%b busy=%b want 0 0", out_valid, busy);
    end
    m_ptr = 1;
  endtask

  task automatic test_all_simul();
    apply_reset();
    for (int i = 0; i < N; i++) sv[i] = i + 1;
    drive_syn();
    req = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'(1 << k)) begin
        errors++;
        $display("FAIL all_gnt%0d: gnt=%b want %b", k, gnt, 4'(1 << k));
      end
      req[k] = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pos !== SW'(gf_pos(k + 1)) ||
          out_id !== IW'(k)) begin
        errors++;
        $display("FAIL all_res%0d: v=%b pos=%0d id=%0d want 1 %0d %0d",
                 k, out_valid, out_pos, out_id, gf_pos(k + 1), k);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL all_idle: busy=%b want 0", busy);
    end
    m_ptr = 0;
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int i = 0; i < N; i++) sv[i] = int'($urandom_range(0, 63));
    drive_syn();
    req = 4'b0010;
    out_ready = 1'b0;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    checks++;
    if (out_id !== 2'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fair_first: id=%0d v=%b want 1 1", out_id, out_valid);
    end
    out_ready = 1'b1;
    req = 4'b0101;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL fair_second: gnt=%b want 0100", gnt);
    end
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (out_id !== 2'd2 || out_pos !== SW'(gf_pos(sv[2]))) begin
      errors++;
      $display("FAIL fair_res2: id=%0d pos=%0d want 2 %0d",
               out_id, out_pos, gf_pos(sv[2]));
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL fair_third: gnt=%b want 0001", gnt);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (out_id !== 2'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fair_res0: id=%0d v=%b want 0 1", out_id, out_valid);
    end
    @(negedge clk);
    m_ptr = 1;
  endtask

  task automatic test_backpressure();
    int s0;
    int s1;
    logic [SW-1:0] held;
    s0 = int'($urandom_range(0, 63));
    sv[1] = s0;
    drive_syn();
    req = 4'b0010;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL bp_gnt: gnt=%b want 0010", gnt);
    end
    s1 = int'($urandom_range(0, 63));
    sv[1] = s1;
    drive_syn();
    @(negedge clk);
    held = SW'(gf_pos(s0));
    checks++;
    if (out_valid !== 1'b1 || out_pos !== held || out_id !== 2'd1) begin
      errors++;
      $display("FAIL bp_res: v=%b pos=%0d id=%0d want 1 %0d 1",
               out_valid, out_pos, out_id, held);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== '0 || out_valid !== 1'b1 || out_pos !== held ||
          out_id !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold%0d: gnt=%b v=%b pos=%0d id=%0d want 0 1 %0d 1",
                 c, gnt, out_valid, out_pos, out_id, held);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: gnt=%b v=%b want 0010 0", gnt, out_valid);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (out_pos !== SW'(gf_pos(s1)) || out_id !== 2'd1) begin
      errors++;
      $display("FAIL bp_res2: pos=%0d id=%0d want %0d 1",
               out_pos, out_id, gf_pos(s1));
    end
    @(negedge clk);
    m_ptr = 2;
  endtask

  task automatic test_boundary();
    int svals [3];
    int want  [3];
    int id;
    svals = '{0, 63, 33};
    want  = '{0, 59, 63};
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      id = int'($urandom_range(0, N - 1));
      sv[id] = svals[b];
      drive_syn();
      req = 4'(1 << id);
      @(negedge clk);
      checks++;
      if (gnt !== 4'(1 << id)) begin
        errors++;
        $display("FAIL bnd_gnt%0d: gnt=%b want %b", b, gnt, 4'(1 << id));
      end
      req = '0;
      @(negedge clk);
      checks++;
      if (out_pos !== SW'(want[b]) || out_pos !== SW'(gf_pos(svals[b])) ||
          out_noerr !== (svals[b] == 0) || out_id !== IW'(id)) begin
        errors++;
        $display("FAIL bnd_syn%0d: pos=%0d ne=%b id=%0d want %0d %0d %0d",
                 svals[b], out_pos, out_noerr, out_id, want[b],
                 svals[b] == 0, id);
      end
      @(negedge clk);
      m_ptr = (id + 1) % N;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b1;
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL rmid_pre: gnt=%b want 1000", gnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_rst: gnt=%b v=%b busy=%b want 0 0 0",
               gnt, out_valid, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_post: gnt=%b want 0001", gnt);
    end
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if (out_id !== 2'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_res: id=%0d v=%b want 0 1", out_id, out_valid);
    end
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    m_ptr = 0;
  endtask

  task automatic test_random(input int n);
    logic [N-1:0]  r;
    logic [N-1:0]  add;
    logic [SW-1:0] held;
    int sel;
    int s;
    int stall;
    r = 4'($urandom_range(1, 15));
    for (int i = 0; i < N; i++) sv[i] = int'($urandom_range(0, 63));
    drive_syn();
    req = r;
    out_ready = 1'b0;
    for (int it = 0; it < n; it++) begin
      @(negedge clk);
      sel = pick(r, m_ptr);
      s = sv[sel];
      checks++;
      if (gnt !== 4'(1 << sel) || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd_gnt%0d: gnt=%b v=%b want %b 0",
                 it, gnt, out_valid, 4'(1 << sel));
      end
      r[sel] = 1'b0;
      req = r;
      sv[sel] = int'($urandom_range(0, 63));
      drive_syn();
      @(negedge clk);
      held = SW'(gf_pos(s));
      checks++;
      if (out_valid !== 1'b1 || out_pos !== held || out_id !== IW'(sel) ||
          out_noerr !== (s == 0) || gnt !== '0) begin
        errors++;
        $display("FAIL rnd_res%0d: v=%b pos=%0d id=%0d ne=%b want 1 %0d %0d %0d",
                 it, out_valid, out_pos, out_id, out_noerr, held, sel, s == 0);
      end
      m_ptr = (sel + 1) % N;
      stall = int'($urandom_range(0, 3));
      out_ready = 1'b0;
      for (int c = 0; c < stall; c++) begin
        @(negedge clk);
        checks++;
        if (gnt !== '0 || out_valid !== 1'b1 || out_pos !== held) begin
          errors++;
          $display("FAIL rnd_hold%0d: gnt=%b v=%b pos=%0d want 0 1 %0d",
                   it, gnt, out_valid, out_pos, held);
        end
      end
      add = ($urandom_range(0, 2) != 0) ? 4'($urandom) : '0;
      for (int i = 0; i < N; i++)
        if (add[i] && !r[i]) sv[i] = int'($urandom_range(0, 63));
      r = r | add;
      drive_syn();
      out_ready = 1'b1;
      req = r;
      if (r == '0) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin
          errors++;
          $display("FAIL rnd_idle%0d: v=%b busy=%b gnt=%b want 0 0 0",
                   it, out_valid, busy, gnt);
        end
        r = 4'($urandom_range(1, 15));
        for (int i = 0; i < N; i++) sv[i] = int'($urandom_range(0, 63));
        drive_syn();
        req = r;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    req = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    syn = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_all_simul();
    test_fairness();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    test_random(80);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
